// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/gnt + rvalid
// memory handshake (one request outstanding), and presents each instruction
// with its PC to decode through a one-entry valid/ready output buffer.
// A redirect from branch resolution flushes buffered and in-flight fetches.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  if_opcode
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e          state;
    state_e          state_nxt;
    logic            drop;
    logic            drop_nxt;
    logic            issue;
    logic            fill;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inflight;
    logic [XLEN-1:0] redirect_aligned;

    // Redirect targets are always word aligned
    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    // FSM state and drop flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
        end
    end

    // Next state, request gating and response acceptance
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        imem_req  = 1'b0;
        issue     = 1'b0;
        fill      = 1'b0;
        case (state)
            S_REQ: begin
                // Only ask for a word when the buffer will be free to take it
                imem_req = rst_n & ~redirect_valid & (~if_valid | if_ready);
                issue    = imem_req & imem_gnt;
                if (issue) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    // Response consumes any pending drop; stale or redirected data is discarded
                    state_nxt = S_REQ;
                    drop_nxt  = 1'b0;
                    fill      = ~drop & ~redirect_valid;
                end else if (redirect_valid) begin
                    drop_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    // Program counter and address of the outstanding fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            pc_inflight <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_aligned;
        end else if (issue) begin
            pc_inflight <= pc;
            pc          <= pc + XLEN'(4);
        end
    end

    // One-entry output buffer towards decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (fill) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= pc_inflight;
        end else if (redirect_valid | if_ready) begin
            if_valid <= 1'b0;
        end
    end

    assign imem_addr = pc;
    assign if_opcode = if_instr[OPC_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: randomized memory/decode environment, an
// event-level reference model feeding expectation queues, and a monitor
// that pops and compares whenever the DUT presents a request or transfer.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } xfer_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;

    // Expectation queues written by the model, drained by the monitor
    bit          exp_req_q[$];
    logic [31:0] exp_addr_q[$];
    xfer_t       exp_data_q[$];

    int n_chk;
    int n_pass;
    int n_xfer;
    int tmo_errs;
    bit done;

    // Memory environment controls
    int          gnt_pct;
    int          lat_min;
    int          lat_max;
    bit          tbl_en;
    int          tbl_idx;
    bit          force_en;
    logic [31:0] force_val;
    bit          mem_pending;
    int          mem_cnt;
    logic [31:0] tbl [5];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_opcode      (if_opcode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pending();
        int k;
        k = 0;
        while (!mem_pending && k < 40) begin
            cyc(1);
            k++;
        end
        if (!mem_pending) tmo_errs++;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!if_valid && k < 40) begin
            cyc(1);
            k++;
        end
        if (!if_valid) tmo_errs++;
    endtask

    // Memory: grants randomly, returns data after a chosen latency
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        mem_pending = 1'b0;
        mem_cnt     = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (mem_pending) begin
                mem_cnt--;
                if (mem_cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    mem_pending = 1'b0;
                    if (tbl_en && tbl_idx < 5) begin
                        imem_rdata = tbl[tbl_idx];
                        tbl_idx++;
                    end else if (force_en) begin
                        imem_rdata = force_val;
                    end
                end
            end
            imem_gnt = !mem_pending && (int'($urandom_range(99, 0)) < gnt_pct);
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                mem_pending = 1'b1;
                mem_cnt     = int'($urandom_range(lat_max, lat_min));
            end
        end
    end

    // Reference model: fetch PC sequence, single outstanding fetch, flush on redirect
    initial begin
        logic [31:0] m_pc;
        logic [31:0] m_inflight;
        bit          outstanding;
        bit          stale;
        bit          can_req;
        xfer_t       x;
        m_pc        = 32'h0;
        m_inflight  = 32'h0;
        outstanding = 1'b0;
        stale       = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pc        = 32'h0;
                outstanding = 1'b0;
                stale       = 1'b0;
                exp_data_q.delete();
                exp_addr_q.delete();
                exp_req_q.push_back(1'b0);
            end else begin
                can_req = !outstanding && !redirect_valid && (exp_data_q.size() == 0 || if_ready);
                exp_req_q.push_back(can_req);
                if (redirect_valid) begin
                    m_pc = redirect_pc & 32'hFFFF_FFFC;
                    exp_data_q.delete();
                    if (outstanding) begin
                        if (imem_rvalid) begin
                            outstanding = 1'b0;
                            stale       = 1'b0;
                        end else begin
                            stale = 1'b1;
                        end
                    end
                end else if (can_req && imem_gnt) begin
                    exp_addr_q.push_back(m_pc);
                    m_inflight  = m_pc;
                    m_pc        = m_pc + 32'd4;
                    outstanding = 1'b1;
                end else if (outstanding && imem_rvalid) begin
                    outstanding = 1'b0;
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        x.pc    = m_inflight;
                        x.instr = imem_rdata;
                        exp_data_q.push_back(x);
                    end
                end
            end
        end
    end

    // Monitor: compare DUT activity against the expectation queues
    initial begin
        bit          e_req;
        xfer_t       e;
        bit          prev_hold;
        bit          prev_wait;
        logic [31:0] prev_instr;
        logic [31:0] prev_pc;
        logic [31:0] prev_addr;
        prev_hold = 1'b0;
        prev_wait = 1'b0;
        prev_instr = '0;
        prev_pc = '0;
        prev_addr = '0;
        while (!done) begin
            @(negedge clk);
            #1;
            if (exp_req_q.size() == 0) begin
                n_chk++;
                $display("FAIL req_model: got no expectation, required one per cycle at %0t", $time);
            end else begin
                e_req = exp_req_q.pop_front();
                chk("imem_req", 32'(imem_req), 32'(e_req));
            end
            if (!rst_n) begin
                chk("rst_if_valid", 32'(if_valid), 32'h0);
                chk("rst_if_instr", if_instr, 32'h0);
                chk("rst_if_pc", if_pc, 32'h0);
                chk("rst_imem_addr", imem_addr, 32'h0);
                prev_hold = 1'b0;
                prev_wait = 1'b0;
                continue;
            end
            if (imem_req && imem_gnt) begin
                if (exp_addr_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL imem_addr: got request %h, required none at %0t", imem_addr, $time);
                end else begin
                    chk("imem_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (prev_hold) begin
                chk("hold_if_valid", 32'(if_valid), 32'h1);
                chk("hold_if_instr", if_instr, prev_instr);
                chk("hold_if_pc", if_pc, prev_pc);
            end
            if (prev_wait) chk("hold_imem_addr", imem_addr, prev_addr);
            if (if_valid && if_ready && !redirect_valid) begin
                if (exp_data_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL xfer_spurious: got pc %h instr %h, required no transfer at %0t",
                             if_pc, if_instr, $time);
                end else begin
                    e = exp_data_q.pop_front();
                    n_xfer++;
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", if_instr, e.instr);
                    chk("if_opcode", 32'(if_opcode), 32'(e.instr[6:0]));
                end
            end
            prev_hold  = if_valid && !if_ready && !redirect_valid;
            prev_wait  = imem_req && !imem_gnt;
            prev_instr = if_instr;
            prev_pc    = if_pc;
            prev_addr  = imem_addr;
        end
        chk("timeouts", 32'(tmo_errs), 32'h0);
        chk("drain", 32'(exp_data_q.size()), 32'h0);
        chk("progress", 32'(n_xfer >= 50), 32'h1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Stimulus: directed scenarios followed by a randomized run
    initial begin
        tbl[0] = 32'h0000_0033;
        tbl[1] = 32'h0050_0093;
        tbl[2] = 32'h0000_2103;
        tbl[3] = 32'h0011_2023;
        tbl[4] = 32'h0020_8463;
        n_chk = 0; n_pass = 0; n_xfer = 0; tmo_errs = 0; done = 1'b0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        tbl_en = 1'b0; tbl_idx = 0; force_en = 1'b0; force_val = 32'hDEAD_BEEF;
        rst_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        #2 rst_n = 1'b0;
        // Reset with random inputs
        repeat (4) begin
            cyc(1);
            redirect_valid = 1'($urandom_range(1, 0));
            redirect_pc    = $urandom;
            if_ready       = 1'($urandom_range(1, 0));
        end
        cyc(1);
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        tbl_en         = 1'b1;
        #2 rst_n = 1'b1;
        // Zero-wait stream of five table instructions
        cyc(12);
        tbl_en = 1'b0;
        // Backpressure for five cycles on a full buffer
        wait_valid();
        if_ready = 1'b0;
        cyc(5);
        if_ready = 1'b1;
        cyc(4);
        // Redirect while a fetch is outstanding; stale data must vanish
        gnt_pct = 0;
        cyc(6);
        lat_min = 4; lat_max = 4; force_en = 1'b1; gnt_pct = 100;
        wait_pending();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(4);
        force_en = 1'b0;
        // Redirect coincident with the response
        gnt_pct = 0;
        cyc(6);
        lat_min = 2; lat_max = 2; gnt_pct = 100;
        wait_pending();
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        cyc(1);
        redirect_valid = 1'b0;
        lat_min = 1; lat_max = 1;
        cyc(6);
        // Redirect while a buffered instruction is being accepted
        wait_valid();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(6);
        // Async reset between edges while waiting; the late response is ignored
        gnt_pct = 0;
        cyc(6);
        lat_min = 5; lat_max = 5; gnt_pct = 100;
        wait_pending();
        gnt_pct = 0;
        #2 rst_n = 1'b0;
        cyc(1);
        #2 rst_n = 1'b1;
        cyc(7);
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        cyc(6);
        // PC wrap from the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(12);
        // Randomized traffic
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        repeat (1500) begin
            if_ready       = ($urandom_range(99, 0) < 70);
            redirect_valid = ($urandom_range(99, 0) < 4);
            redirect_pc    = $urandom;
            cyc(1);
        end
        // Drain: no new grants, decode always ready
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        gnt_pct        = 0;
        cyc(12);
        done = 1'b1;
    end

endmodule
